// File: rtl/sbox_issue_sched.sv
// Issue scheduler for the shared 2-share masked S-box: one pass of NBYTES bytes, randomness
// handshake with bubbles, random-input alignment and write-back tagging. Macro SBOX_SCHED_STALL_CNT_EN adds stall_cnt.
module sbox_issue_sched #(
  parameter int NBYTES   = 16,
  parameter int AW       = 4,
  parameter int SBOX_LAT = 4,
  parameter int RAND_OFS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  output logic          sb_issue,
  output logic [7:0]    sb_guards,
  output logic [3:0]    sb_random,
  input  logic [11:0]   rnd_data,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr
`ifdef SBOX_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state;
  logic [AW-1:0]        idx;
  logic                 issue;
  logic [SBOX_LAT-1:0]  vPipe;
  logic [AW-1:0]        aPipe [SBOX_LAT];
  logic [SBOX_LAT-1:0]  tailMask;
  logic                 drainDone;

  assign issue     = (state == ISSUE) && rnd_valid;
  assign sb_issue  = issue;
  assign rnd_ready = issue;
  assign rd_addr   = (state == ISSUE) ? idx : '0;
  assign sb_guards = issue ? rnd_data[7:0] : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // The tail entry is being written this cycle, so draining ends once only it may be valid.
  assign tailMask  = SBOX_LAT'(1) << (SBOX_LAT - 1);
  assign drainDone = ~|(vPipe & ~tailMask);

  assign wr_en     = vPipe[SBOX_LAT-1];
  assign wr_addr   = aPipe[SBOX_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            idx   <= '0;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (idx == AW'(NBYTES - 1)) state <= DRAIN;
            else                        idx   <= idx + 1'b1;
          end
        end
        DRAIN: begin
          if (drainDone) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vPipe <= '0;
      for (int unsigned i = 0; i < SBOX_LAT; i++) aPipe[i] <= '0;
    end else begin
      vPipe[0] <= issue;
      aPipe[0] <= issue ? idx : '0;
      for (int unsigned i = 1; i < SBOX_LAT; i++) begin
        vPipe[i] <= vPipe[i-1];
        aPipe[i] <= aPipe[i-1];
      end
    end
  end

  generate
    if (RAND_OFS == 0) begin : gRandComb
      assign sb_random = issue ? rnd_data[11:8] : '0;
    end else begin : gRandLine
      logic [3:0] rLine [RAND_OFS];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < RAND_OFS; i++) rLine[i] <= '0;
        end else begin
          rLine[0] <= issue ? rnd_data[11:8] : '0;
          for (int unsigned i = 1; i < RAND_OFS; i++) rLine[i] <= rLine[i-1];
        end
      end
      assign sb_random = rLine[RAND_OFS-1];
    end
  endgenerate

`ifdef SBOX_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == ISSUE && !rnd_valid && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sbox_issue_sched.sv
// Randomized self-checking bench for sbox_issue_sched, compared against a pass-level timing model.
`timescale 1ns/1ps
module tb_sbox_issue_sched;
  localparam int NB   = 16;
  localparam int AW   = 4;
  localparam int LAT  = 4;
  localparam int OFS  = 2;
  localparam int MAXC = 256;

  logic clk = 1'b0;
  logic rst, start, rndValid;
  logic [11:0] rndData;
  logic busy, done, sbIssue, rndReady, wrEn;
  logic [AW-1:0] rdAddr, wrAddr;
  logic [7:0] sbGuards;
  logic [3:0] sbRandom;

  logic start2, rndValid2;
  logic [11:0] rndData2;
  logic busy2, done2, sbIssue2, rndReady2, wrEn2;
  logic [0:0] rdAddr2, wrAddr2;
  logic [7:0] sbGuards2;
  logic [3:0] sbRandom2;
`ifdef SBOX_SCHED_STALL_CNT_EN
  logic [15:0] stallCnt, stallCnt2;
`endif

  int checks = 0;
  int errors = 0;

  bit            vld    [MAXC];
  logic [11:0]   dat    [MAXC];
  bit            eIss   [MAXC];
  logic [AW-1:0] eAddr  [MAXC];
  logic [7:0]    eGuard [MAXC];
  logic [3:0]    eRand  [MAXC];
  bit            eWr    [MAXC];
  logic [AW-1:0] eWrA   [MAXC];
  int doneCyc, expStall;

  always #5 clk = ~clk;

  sbox_issue_sched #(.NBYTES(NB), .AW(AW), .SBOX_LAT(LAT), .RAND_OFS(OFS)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rdAddr), .sb_issue(sbIssue), .sb_guards(sbGuards), .sb_random(sbRandom),
    .rnd_data(rndData), .rnd_valid(rndValid), .rnd_ready(rndReady),
    .wr_en(wrEn), .wr_addr(wrAddr)
`ifdef SBOX_SCHED_STALL_CNT_EN
    , .stall_cnt(stallCnt)
`endif
  );

  sbox_issue_sched #(.NBYTES(2), .AW(1), .SBOX_LAT(1), .RAND_OFS(0)) dutSmall (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .rd_addr(rdAddr2), .sb_issue(sbIssue2), .sb_guards(sbGuards2), .sb_random(sbRandom2),
    .rnd_data(rndData2), .rnd_valid(rndValid2), .rnd_ready(rndReady2),
    .wr_en(wrEn2), .wr_addr(wrAddr2)
`ifdef SBOX_SCHED_STALL_CNT_EN
    , .stall_cnt(stallCnt2)
`endif
  );

  // Cycle k of a pass: byte n goes out on the n-th cycle with randomness, writes LAT later,
  // random appears OFS later, done one cycle after the last write.
  task automatic build_model();
    int n = 0;
    int lastIss = MAXC;
    expStall = 0;
    for (int k = 0; k < MAXC; k++) begin
      eIss[k] = 0; eAddr[k] = '0; eGuard[k] = '0; eRand[k] = '0; eWr[k] = 0; eWrA[k] = '0;
    end
    for (int k = 1; k < MAXC && n < NB; k++) begin
      eAddr[k] = AW'(n);
      if (vld[k]) begin
        eIss[k]   = 1;
        eGuard[k] = dat[k][7:0];
        n++;
        if (n == NB) lastIss = k;
      end else begin
        expStall++;
      end
    end
    doneCyc = lastIss + LAT + 1;
    for (int k = 0; k < MAXC; k++) begin
      if (k >= LAT && eIss[k-LAT]) begin eWr[k] = 1; eWrA[k] = eAddr[k-LAT]; end
      if (k >= OFS && eIss[k-OFS]) eRand[k] = dat[k-OFS][11:8];
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; rndValid = 1'b1; rndData = 12'hFFF;
    @(negedge clk);
    checks++;
    if ({busy, done, sbIssue, rndReady, wrEn, rdAddr, wrAddr, sbGuards, sbRandom} !== '0) begin
      errors++;
      $display("FAIL reset_in: outputs %b expected all 0",
               {busy, done, sbIssue, rndReady, wrEn, rdAddr, wrAddr, sbGuards, sbRandom});
    end
    next_cycle();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, sbIssue, rndReady, wrEn, rdAddr, wrAddr, sbGuards, sbRandom} !== '0) begin
      errors++;
      $display("FAIL reset_idle: outputs %b expected all 0",
               {busy, done, sbIssue, rndReady, wrEn, rdAddr, wrAddr, sbGuards, sbRandom});
    end
    next_cycle();
  endtask

  task automatic test_random_passes();
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < MAXC; k++) begin
        if (p == 0 || p == 7) begin
          vld[k] = 1; dat[k] = (p == 0) ? 12'hA5C : 12'($urandom);
        end else if (p == 1) begin
          vld[k] = (k != 3 && k != 4); dat[k] = 12'($urandom);
        end else begin
          vld[k] = ($urandom_range(0, 3) != 0) || (k > 100); dat[k] = 12'($urandom);
        end
      end
      build_model();
      start = 1'b1; rndValid = 1'b0;
      next_cycle();
      start = 1'b0;
      for (int k = 1; k <= doneCyc + 1; k++) begin
        rndValid = vld[k]; rndData = dat[k];
        @(negedge clk);
        checks++;
        if (sbIssue !== eIss[k] || rndReady !== eIss[k]) begin
          errors++;
          $display("FAIL p%0d c%0d issue: got %b/%b exp %b", p, k, sbIssue, rndReady, eIss[k]);
        end
        checks++;
        if (rdAddr !== eAddr[k]) begin
          errors++; $display("FAIL p%0d c%0d rd_addr: got %0d exp %0d", p, k, rdAddr, eAddr[k]);
        end
        checks++;
        if (sbGuards !== eGuard[k]) begin
          errors++; $display("FAIL p%0d c%0d guards: got %h exp %h", p, k, sbGuards, eGuard[k]);
        end
        checks++;
        if (sbRandom !== eRand[k]) begin
          errors++; $display("FAIL p%0d c%0d random: got %h exp %h", p, k, sbRandom, eRand[k]);
        end
        checks++;
        if (wrEn !== eWr[k]) begin
          errors++; $display("FAIL p%0d c%0d wr_en: got %b exp %b", p, k, wrEn, eWr[k]);
        end
        if (eWr[k]) begin
          checks++;
          if (wrAddr !== eWrA[k]) begin
            errors++; $display("FAIL p%0d c%0d wr_addr: got %0d exp %0d", p, k, wrAddr, eWrA[k]);
          end
        end
        checks++;
        if (busy !== (k <= doneCyc) || done !== (k == doneCyc)) begin
          errors++;
          $display("FAIL p%0d c%0d busy/done: got %b/%b exp %b/%b", p, k, busy, done,
                   k <= doneCyc, k == doneCyc);
        end
`ifdef SBOX_SCHED_STALL_CNT_EN
        if (k == doneCyc + 1) begin
          checks++;
          if (stallCnt !== 16'(expStall)) begin
            errors++; $display("FAIL p%0d stall_cnt: got %0d exp %0d", p, stallCnt, expStall);
          end
        end
`endif
        next_cycle();
      end
    end
  endtask

  task automatic test_start_ignored();
    int writes = 0;
    int dones = 0;
    int doneAt = -1;
    bit busyAfter = 0;
    start = 1'b1; rndValid = 1'b1; rndData = 12'h123;
    next_cycle();
    for (int k = 1; k <= 30; k++) begin
      start = (k == 6 || k == 21);
      @(negedge clk);
      if (wrEn) begin
        checks++;
        if (wrAddr !== AW'(writes)) begin
          errors++; $display("FAIL start_ign order c%0d: got %0d exp %0d", k, wrAddr, writes);
        end
        writes++;
      end
      if (done) begin dones++; doneAt = k; end
      if (k >= 22 && busy) busyAfter = 1;
      next_cycle();
    end
    start = 1'b0;
    checks++;
    if (writes != NB || dones != 1 || doneAt != 21) begin
      errors++;
      $display("FAIL start_ign counts: writes %0d dones %0d at %0d exp 16 1 21", writes, dones, doneAt);
    end
    checks++;
    if (busyAfter) begin errors++; $display("FAIL start_ign restart: busy after done got 1 exp 0"); end
  endtask

  task automatic test_rst_midpass();
    bit sawWr = 0;
    bit sawBusy = 0;
    int writes = 0;
    int doneAt = -1;
    start = 1'b1; rndValid = 1'b1; rndData = 12'hFFF;
    next_cycle();
    start = 1'b0;
    repeat (7) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, sbIssue, rndReady, wrEn, rdAddr, wrAddr, sbGuards, sbRandom} !== '0) begin
      errors++;
      $display("FAIL rst_mid c9: outputs %b expected all 0",
               {busy, done, sbIssue, rndReady, wrEn, rdAddr, wrAddr, sbGuards, sbRandom});
    end
    next_cycle();
    for (int k = 10; k <= 30; k++) begin
      @(negedge clk);
      if (wrEn) sawWr = 1;
      if (busy) sawBusy = 1;
      next_cycle();
    end
    checks++;
    if (sawWr || sawBusy) begin
      errors++; $display("FAIL rst_mid after: wr_en/busy got %b/%b exp 0/0", sawWr, sawBusy);
    end
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (wrEn) writes++;
      if (done) doneAt = k;
      next_cycle();
    end
    checks++;
    if (writes != NB || doneAt != 21) begin
      errors++; $display("FAIL rst_mid repass: writes %0d done %0d exp 16 21", writes, doneAt);
    end
  endtask

  task automatic test_rnd_low();
    start = 1'b1; rndValid = 1'b0;
    next_cycle();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || sbIssue !== 1'b0 || rndReady !== 1'b0 || wrEn !== 1'b0 || rdAddr !== '0) begin
        errors++;
        $display("FAIL rnd_low c%0d: busy %b issue %b ready %b wr %b rd %0d exp 1 0 0 0 0",
                 k, busy, sbIssue, rndReady, wrEn, rdAddr);
      end
      next_cycle();
    end
`ifdef SBOX_SCHED_STALL_CNT_EN
    @(negedge clk);
    checks++;
    if (stallCnt !== 16'd40) begin errors++; $display("FAIL rnd_low stall_cnt: got %0d exp 40", stallCnt); end
    next_cycle();
`endif
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_small();
    start2 = 1'b1; rndValid2 = 1'b1; rndData2 = '0;
    next_cycle();
    start2 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      rndData2 = 12'($urandom);
      @(negedge clk);
      checks++;
      if (sbIssue2 !== (k <= 2) || rdAddr2 !== ((k <= 2) ? 1'(k - 1) : 1'b0) ||
          sbGuards2 !== ((k <= 2) ? rndData2[7:0] : 8'h00) ||
          sbRandom2 !== ((k <= 2) ? rndData2[11:8] : 4'h0)) begin
        errors++;
        $display("FAIL small c%0d issue: iss %b rd %0d g %h r %h data %h", k, sbIssue2, rdAddr2,
                 sbGuards2, sbRandom2, rndData2);
      end
      checks++;
      if (wrEn2 !== (k == 2 || k == 3) || ((k == 2 || k == 3) && wrAddr2 !== 1'(k - 2))) begin
        errors++; $display("FAIL small c%0d wr: got %b/%0d exp %b", k, wrEn2, wrAddr2, k == 2 || k == 3);
      end
      checks++;
      if (done2 !== (k == 4) || busy2 !== (k <= 4)) begin
        errors++; $display("FAIL small c%0d busy/done: got %b/%b exp %b/%b", k, busy2, done2, k <= 4, k == 4);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rndValid = 1'b0; rndData = '0;
    start2 = 1'b0; rndValid2 = 1'b0; rndData2 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_random_passes();
    test_start_ignored();
    test_rst_midpass();
    test_rnd_low();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
